// File: rtl/regfile_commit_sched_if.sv
// ----------------------------------------------------------------------------
// regfile_commit_sched_if
//   Bundles the ROB commit ports, the single regfile write port and the
//   issue-side lookup of regfile_commit_sched.
//
//   master : the ROB / issue side. It drives the commits and query_idx, and it
//            observes commit_ready, the write port and the lookup result.
//   slave  : the scheduler.
//
//   Signals
//     c0_*            older commit write (valid, dest idx, value, ROB tag)
//     c1_*            younger commit write (same meaning)
//     commit_ready    ROB may present up to two commits this cycle
//     rob_set_*       regfile write port (idx 0 = no write)
//     query_idx       issue-side lookup register
//     query_hit       a pending write to query_idx exists
//     query_val       value of the youngest pending write to query_idx
// ----------------------------------------------------------------------------
interface regfile_commit_sched_if #(
  parameter int ROB_SIZE_BIT = 4
);
  logic                    c0_valid;
  logic [4:0]              c0_idx;
  logic [31:0]             c0_val;
  logic [ROB_SIZE_BIT-1:0] c0_rob;
  logic                    c1_valid;
  logic [4:0]              c1_idx;
  logic [31:0]             c1_val;
  logic [ROB_SIZE_BIT-1:0] c1_rob;
  logic                    commit_ready;
  logic [4:0]              rob_set_idx;
  logic [31:0]             rob_set_reg_val;
  logic [ROB_SIZE_BIT-1:0] rob_set_recorder;
  logic [4:0]              query_idx;
  logic                    query_hit;
  logic [31:0]             query_val;

  modport master (
    output c0_valid, c0_idx, c0_val, c0_rob,
    output c1_valid, c1_idx, c1_val, c1_rob,
    output query_idx,
    input  commit_ready,
    input  rob_set_idx, rob_set_reg_val, rob_set_recorder,
    input  query_hit, query_val
  );

  modport slave (
    input  c0_valid, c0_idx, c0_val, c0_rob,
    input  c1_valid, c1_idx, c1_val, c1_rob,
    input  query_idx,
    output commit_ready,
    output rob_set_idx, rob_set_reg_val, rob_set_recorder,
    output query_hit, query_val
  );
endinterface

// File: rtl/regfile_commit_sched.sv
// ----------------------------------------------------------------------------
// regfile_commit_sched
//   Write-port scheduler between the ROB commit stage and a single-write-port
//   register file. Up to two retired writes per cycle are accepted, queued in
//   age order and drained one per cycle onto the regfile write port. A
//   combinational lookup exposes retired-but-unwritten values to issue.
//
//   Ports
//     clk_in        system clock, rising edge
//     rst_n_in      asynchronous active-low reset
//     rdy_in        global ready; low freezes all state
//     rob_clear     ROB flush; retired writes are kept and still drain
//     bus           commit / write-port / lookup bundle (slave side)
//     drained       queue empty and output register idle
//     overflow_err  sticky: a commit arrived while not accepted
// ----------------------------------------------------------------------------
module regfile_commit_sched #(
  parameter int ROB_SIZE_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   rob_clear,
  regfile_commit_sched_if.slave  bus,
  output logic                   drained,
  output logic                   overflow_err
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]              idx;
    logic [31:0]             val;
    logic [ROB_SIZE_BIT-1:0] rob;
  } wr_t;

  wr_t           mem [DEPTH];
  wr_t           out_q;
  wr_t           out_next;
  wr_t           c0_w;
  wr_t           c1_w;
  wr_t           enq_a;
  wr_t           enq_b;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    n_enq;
  logic          ready;
  logic          acc0;
  logic          acc1;
  logic          head_vld;
  logic          ovf_evt;

  // A flush only squashes speculative ROB state; everything that reached this
  // block has already retired and must still land in the register file.
  logic unused_rob_clear;
  assign unused_rob_clear = rob_clear;

  // Two free slots guarantee both commits fit even when nothing dequeues.
  assign ready            = rdy_in && ((DEPTH_C - count) >= CW'(2));
  assign bus.commit_ready = ready;

  assign c0_w = '{idx: bus.c0_idx, val: bus.c0_val, rob: bus.c0_rob};
  assign c1_w = '{idx: bus.c1_idx, val: bus.c1_val, rob: bus.c1_rob};

  // Writes to x0 are architecturally void: never queued, never an error.
  assign acc0     = bus.c0_valid && (bus.c0_idx != 5'd0) && ready;
  assign acc1     = bus.c1_valid && (bus.c1_idx != 5'd0) && ready;
  assign ovf_evt  = rdy_in && !ready &&
                    ((bus.c0_valid && (bus.c0_idx != 5'd0)) ||
                     (bus.c1_valid && (bus.c1_idx != 5'd0)));
  assign head_vld = (count != '0);

  // Age order is queue head, then c0, then c1. The oldest goes to the output
  // register, the rest are appended to the queue.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    out_next = '0;
    enq_a    = '0;
    enq_b    = '0;
    n_enq    = 2'd0;
    if (head_vld) begin
      out_next = mem[rd_ptr];
      if (acc0) begin
        enq_a = c0_w;
        if (acc1) begin
          enq_b = c1_w;
          n_enq = 2'd2;
        end else begin
          n_enq = 2'd1;
        end
      end else if (acc1) begin
        enq_a = c1_w;
        n_enq = 2'd1;
      end
    end else if (acc0) begin
      out_next = c0_w;
      if (acc1) begin
        enq_a = c1_w;
        n_enq = 2'd1;
      end
    end else if (acc1) begin
      out_next = c1_w;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n_in) begin
      out_q        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (rdy_in) begin
      out_q  <= out_next;
      rd_ptr <= rd_ptr + PW'(head_vld);
      wr_ptr <= wr_ptr + PW'(n_enq);
      count  <= count + CW'(n_enq) - CW'(head_vld);
      if (ovf_evt) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale slot
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (n_enq != 2'd0) begin
        mem[wr_ptr] <= enq_a;
      end
      if (n_enq == 2'd2) begin
        mem[wr_ptr + PW'(1)] <= enq_b;
      end
    end
  end

  assign bus.rob_set_idx      = out_q.idx;
  assign bus.rob_set_reg_val  = out_q.val;
  assign bus.rob_set_recorder = out_q.rob;

  assign drained = (count == '0) && (out_q.idx == 5'd0);

  // Lookup: output register has the lowest priority; queue entries are
  // scanned oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    bus.query_hit = 1'b0;
    bus.query_val = '0;
    if (bus.query_idx != 5'd0) begin
      if (out_q.idx == bus.query_idx) begin
        bus.query_hit = 1'b1;
        bus.query_val = out_q.val;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count) && (mem[rd_ptr + PW'(k)].idx == bus.query_idx)) begin
          bus.query_hit = 1'b1;
          bus.query_val = mem[rd_ptr + PW'(k)].val;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_commit_sched.sv
// ----------------------------------------------------------------------------
// tb_regfile_commit_sched
//   Self-checking bench for regfile_commit_sched. A reference model keeps the
//   retired-but-unwritten writes as an ordered list: accepted commits are
//   appended, and each ready cycle the oldest element (if any) becomes the
//   regfile write. Directed scenarios are followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_regfile_commit_sched;
  localparam int RSB   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]     idx;
    logic [31:0]    val;
    logic [RSB-1:0] rob;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;
  logic clr   = 1'b0;
  logic drained;
  logic ovf;

  regfile_commit_sched_if #(.ROB_SIZE_BIT(RSB)) bus ();

  regfile_commit_sched #(
    .ROB_SIZE_BIT(RSB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .rdy_in      (rdy),
    .rob_clear   (clr),
    .bus         (bus),
    .drained     (drained),
    .overflow_err(ovf)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  wr_t mq[$];
  wr_t mout = '{idx: 5'd0, val: 32'd0, rob: '0};
  bit  movf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input logic r);
    return r && ((DEPTH - mq.size()) >= 2);
  endfunction

  task automatic m_query(input logic [4:0] qi, output logic h, output logic [31:0] v);
    h = 1'b0;
    v = 32'd0;
    if (qi != 5'd0) begin
      if (mout.idx == qi) begin
        h = 1'b1;
        v = mout.val;
      end
      foreach (mq[k]) begin
        if (mq[k].idx == qi) begin
          h = 1'b1;
          v = mq[k].val;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        h;
    logic [31:0] v;
    m_query(bus.query_idx, h, v);
    check({tag, ".idx"},       bus.rob_set_idx,      mout.idx);
    check({tag, ".val"},       bus.rob_set_reg_val,  mout.val);
    check({tag, ".rec"},       bus.rob_set_recorder, mout.rob);
    check({tag, ".drained"},   drained,              (mq.size() == 0) && (mout.idx == 5'd0));
    check({tag, ".ovf"},       ovf,                  movf);
    check({tag, ".qhit"},      bus.query_hit,        h);
    check({tag, ".qval"},      bus.query_val,        v);
  endtask

  // Entered and left at posedge+1; drives inputs, checks commit_ready before
  // the edge and all outputs after it.
  task automatic step(input string tag, input logic r, input logic cl,
                      input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                      input logic [RSB-1:0] t0,
                      input logic v1, input logic [4:0] i1, input logic [31:0] d1,
                      input logic [RSB-1:0] t1);
    bit exp_rdy;
    rdy          = r;
    clr          = cl;
    bus.c0_valid = v0;
    bus.c0_idx   = i0;
    bus.c0_val   = d0;
    bus.c0_rob   = t0;
    bus.c1_valid = v1;
    bus.c1_idx   = i1;
    bus.c1_val   = d1;
    bus.c1_rob   = t1;
    #1;
    exp_rdy = m_ready(r);
    check({tag, ".commit_ready"}, bus.commit_ready, exp_rdy);
    @(posedge clk);
    if (r) begin
      if (v0 && (i0 != 5'd0)) begin
        if (exp_rdy) mq.push_back('{idx: i0, val: d0, rob: t0});
        else movf = 1'b1;
      end
      if (v1 && (i1 != 5'd0)) begin
        if (exp_rdy) mq.push_back('{idx: i1, val: d1, rob: t1});
        else movf = 1'b1;
      end
      if (mq.size() > 0) mout = mq.pop_front();
      else mout = '{idx: 5'd0, val: 32'd0, rob: '0};
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic r);
    step(tag, r, 1'b0, 1'b0, 5'd0, 32'd0, '0, 1'b0, 5'd0, 32'd0, '0);
  endtask

  task automatic rand_step(input string tag, input bit gated);
    logic r;
    logic v0, v1;
    r  = ($urandom_range(0, 7) != 0);
    v0 = $urandom_range(0, 1);
    v1 = $urandom_range(0, 1);
    if (gated && !m_ready(r)) begin
      v0 = 1'b0;
      v1 = 1'b0;
    end
    bus.query_idx = 5'($urandom_range(0, 7));
    step(tag, r, 1'($urandom_range(0, 1)),
         v0, 5'($urandom_range(0, 7)), $urandom, RSB'($urandom),
         v1, 5'($urandom_range(0, 7)), $urandom, RSB'($urandom));
  endtask

  initial begin
    bus.c0_valid  = 1'b0;
    bus.c0_idx    = '0;
    bus.c0_val    = '0;
    bus.c0_rob    = '0;
    bus.c1_valid  = 1'b0;
    bus.c1_idx    = '0;
    bus.c1_val    = '0;
    bus.c1_rob    = '0;
    bus.query_idx = 5'd5;
    rdy           = 1'b1;

    // Reset state.
    #1;
    check("rst.idx",          bus.rob_set_idx,      5'd0);
    check("rst.val",          bus.rob_set_reg_val,  32'd0);
    check("rst.rec",          bus.rob_set_recorder, 4'd0);
    check("rst.ovf",          ovf,                  1'b0);
    check("rst.commit_ready", bus.commit_ready,     1'b1);
    check("rst.drained",      drained,              1'b1);
    check("rst.qhit",         bus.query_hit,        1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single commit lands on the very next edge, then the port goes idle.
    step("t1", 1, 0, 1, 5'd5, 32'hAAAA_0001, 4'd3, 0, 5'd0, 32'd0, 4'd0);
    check("t1.idx_const", bus.rob_set_idx,      5'd5);
    check("t1.val_const", bus.rob_set_reg_val,  32'hAAAA_0001);
    check("t1.rec_const", bus.rob_set_recorder, 4'd3);
    idle("t1.idle", 1);
    check("t1.drained_const", drained, 1'b1);

    // Three dual commits back to back, then drain: x1,x2,x1,x2,x1,x2.
    bus.query_idx = 5'd2;
    for (int i = 0; i < 3; i++) begin
      step("t2.dual", 1, 0, 1, 5'd1, 32'h11, 4'(2 * i), 1, 5'd2, 32'h22, 4'(2 * i + 1));
      check("t2.order", bus.rob_set_idx, (i % 2 == 0) ? 5'd1 : 5'd2);
    end
    bus.c0_valid = 1'b0;
    bus.c1_valid = 1'b0;
    #1;
    check("t2.ready_low", bus.commit_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle("t2.drain", 1);
      if (i < 3) check("t2.order_drain", bus.rob_set_idx, (i % 2 == 0) ? 5'd2 : 5'd1);
    end
    check("t2.ovf_const", ovf, 1'b0);

    // Two pending writes to x7: the younger value wins the lookup.
    step("t3.a", 1, 0, 1, 5'd9, 32'h99, 4'd1, 1, 5'd8, 32'h88, 4'd2);
    step("t3.b", 1, 0, 1, 5'd7, 32'h10, 4'd3, 1, 5'd7, 32'h20, 4'd4);
    rdy = 1'b0;
    bus.c0_valid = 1'b0;
    bus.c1_valid = 1'b0;
    bus.query_idx = 5'd7;
    #1;
    check("t3.qhit7", bus.query_hit, 1'b1);
    check("t3.qval7", bus.query_val, 32'h20);
    bus.query_idx = 5'd0;
    #1;
    check("t3.qhit0", bus.query_hit, 1'b0);
    check("t3.qval0", bus.query_val, 32'd0);
    for (int i = 0; i < 4; i++) idle("t3.drain", 1);

    // c0 to x0 is dropped, c1 alone is written.
    bus.query_idx = 5'd3;
    step("t4", 1, 0, 1, 5'd0, 32'hDEAD, 4'd5, 1, 5'd3, 32'h33, 4'd6);
    check("t4.idx_const", bus.rob_set_idx, 5'd3);
    idle("t4.idle", 1);
    check("t4.idx_idle", bus.rob_set_idx, 5'd0);

    // Fill, freeze for five cycles with a flush pulse, then drain.
    for (int i = 0; i < 4 && m_ready(1'b1); i++) begin
      step("t5.fill", 1, 0, 1, 5'(10 + i), 32'(i), 4'(i), 1, 5'(20 + i), 32'(100 + i), 4'(i + 8));
    end
    for (int i = 0; i < 5; i++) begin
      step("t5.frozen", 0, (i == 2), 1, 5'd4, $urandom, 4'd1, 1, 5'd6, $urandom, 4'd2);
    end
    check("t5.ovf_frozen", ovf, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) idle("t5.drain", 1);
    check("t5.drained", drained, 1'b1);

    // Randomized traffic without overflow.
    for (int i = 0; i < 200; i++) rand_step("rndA", 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) idle("rndA.drain", 1);

    // Overflow is sticky; async reset mid-drain clears outputs at once.
    bus.query_idx = 5'd1;
    for (int i = 0; i < 4 && m_ready(1'b1); i++) begin
      step("t6.fill", 1, 0, 1, 5'd1, 32'(i + 1), 4'd1, 1, 5'd2, 32'(i + 50), 4'd2);
    end
    step("t6.ovf", 1, 0, 1, 5'd12, 32'h1234, 4'd7, 0, 5'd0, 32'd0, 4'd0);
    check("t6.ovf_set", ovf, 1'b1);
    idle("t6.sticky", 1);
    check("t6.ovf_sticky", ovf, 1'b1);
    rdy   = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    mout  = '{idx: 5'd0, val: 32'd0, rob: '0};
    movf  = 1'b0;
    #1;
    check("t6.rst_idx",     bus.rob_set_idx,      5'd0);
    check("t6.rst_val",     bus.rob_set_reg_val,  32'd0);
    check("t6.rst_rec",     bus.rob_set_recorder, 4'd0);
    check("t6.rst_ovf",     ovf,                  1'b0);
    check("t6.rst_drained", drained,              1'b1);
    check("t6.rst_qhit",    bus.query_hit,        1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("t6.post", 1);

    // Randomized traffic including overflow.
    for (int i = 0; i < 150; i++) rand_step("rndB", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
